wb_stage: RTL



---
 rtl/wb_stage.sv | 128 ++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// MEM/WB register and write-back select; an LDW is split into two register-file writes.
// Latency: accept at edge N drives WR/R_dest/WBData in cycle N+1. A legal LDW holds in_ready low for one cycle.
// Optional build macro WB_RETIRE_CNT_EN adds retire_cnt, a count of retired writers.
module wb_stage #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int PC_REG = 30
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_rd,
    input  logic [1:0]    in_wb_sel,
    input  logic          in_is_ldw,
    input  logic [DW-1:0] in_alu,
    input  logic [DW-1:0] in_mem,
    input  logic [DW-1:0] in_mem_hi,
    input  logic [DW-1:0] in_pc,
`ifdef WB_RETIRE_CNT_EN
    output logic [31:0]   retire_cnt,
`endif
    output logic          WR,
    output logic [AW-1:0] R_dest,
    output logic [DW-1:0] WBData,
    output logic          ldw_err
);

    typedef enum logic {IDLE, HI} state_t;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] dat;
    } hi_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_ALU  = 2'b01;
    localparam logic [1:0] SEL_MEM  = 2'b10;
    localparam logic [1:0] SEL_CALL = 2'b11;
    localparam logic [AW-1:0] PC_IDX = AW'(PC_REG);

    state_t        state, state_nxt;
    hi_t           hi_q, hi_nxt;
    logic          wr_nxt;
    logic [AW-1:0] rd_nxt;
    logic [DW-1:0] dat_nxt;
    logic          err_nxt;

    logic accept;
    logic ldw_sel;
    logic ldw_ok;
    logic ldw_bad;
    logic wr_mask_ok;

    assign in_ready   = (state == IDLE);
    assign accept     = in_valid && in_ready;
    // in_is_ldw only means something for a memory-result instruction
    assign ldw_sel    = in_is_ldw && (in_wb_sel == SEL_MEM);
    assign ldw_ok     = ldw_sel && !in_rd[0] && (in_rd != PC_IDX);
    assign ldw_bad    = ldw_sel && !ldw_ok;
    assign wr_mask_ok = (in_wb_sel != SEL_NONE) && (in_rd != '0) && (in_rd != PC_IDX);

    always_comb begin
        state_nxt = state;
        hi_nxt    = hi_q;
        wr_nxt    = 1'b0;
        rd_nxt    = R_dest;
        dat_nxt   = WBData;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    wr_nxt  = wr_mask_ok;
                    rd_nxt  = in_rd;
                    err_nxt = ldw_bad;
                    case (in_wb_sel)
                        SEL_ALU:  dat_nxt = in_alu;
                        SEL_MEM:  dat_nxt = in_mem;
                        SEL_CALL: dat_nxt = in_pc + DW'(1);
                        default:  dat_nxt = WBData;
                    endcase
                    if (ldw_ok) begin
                        hi_nxt.rd  = in_rd + AW'(1);
                        hi_nxt.dat = in_mem_hi;
                        state_nxt  = HI;
                    end
                end
            end
            HI: begin
                // Destination is odd and below PC_REG here, so the write is never masked
                wr_nxt    = 1'b1;
                rd_nxt    = hi_q.rd;
                dat_nxt   = hi_q.dat;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            hi_q    <= '0;
            WR      <= 1'b0;
            R_dest  <= '0;
            WBData  <= '0;
            ldw_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            hi_q    <= hi_nxt;
            WR      <= wr_nxt;
            R_dest  <= rd_nxt;
            WBData  <= dat_nxt;
            ldw_err <= err_nxt;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (accept && (in_wb_sel != SEL_NONE)) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end
`endif

endmodule
